// File: rtl/dma_cmd_seq.sv
// dma_cmd_seq: queues DMA transfer descriptors and programs the dma block
// over its aux parameter-register bus, one descriptor at a time.
// Each descriptor is handled in four steps:
//   1. write the six parameter registers,
//   2. wait for the dma irq,
//   3. acknowledge it,
//   4. wait for the irq to drop before taking the next descriptor.
//
// Optional feature macro: DMA_CMD_SEQ_TIMEOUT_EN
//   Adds an irq watchdog. When the irq does not arrive, the block pulses err
//   and dma_ack, and moves on without reporting done.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   desc_valid/desc_ready         descriptor handshake (ready = FIFO not full)
//   desc_src/desc_dst/desc_n      descriptor fields
//   dma_auxdaddr/dma_auxdin       aux register write bus to the dma
//   dma_irq/dma_ack               dma completion interrupt and acknowledge
//   busy                          descriptor in progress
//   done                          one-cycle pulse per completed descriptor
//   pending                       FIFO occupancy
//   err                           one-cycle pulse on irq timeout
module dma_cmd_seq #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         desc_valid,
  output logic                         desc_ready,
  input  logic [15:0]                  desc_src,
  input  logic [15:0]                  desc_dst,
  input  logic [7:0]                   desc_n,
  output logic [15:0]                  dma_auxdaddr,
  output logic [7:0]                   dma_auxdin,
  input  logic                         dma_irq,
  output logic                         dma_ack,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(FIFO_DEPTH):0]  pending,
  output logic                         err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, WR, WAIT_IRQ, ACK, DRAIN, TMO} state_e;

  state_e          state_q, state_d;
  logic [39:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     curSrc_q, curDst_q;
  logic [7:0]      curN_q;
  logic [2:0]      idx_q;
  logic [HW-1:0]   hold_q;
  logic [15:0]     auxAddr_q, auxAddr_d;
  logic [7:0]      auxData_q, auxData_d;
  logic            full, empty, push, pop, lastBeat;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = desc_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign lastBeat   = (hold_q == HW'(HOLD_CYCLES - 1));
  assign desc_ready = !full;
  assign pending    = count_q;

  // Occupancy is unchanged when a push and a pop happen together.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Descriptor storage is not reset; occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {desc_src, desc_dst, desc_n};
  end

`ifdef DMA_CMD_SEQ_TIMEOUT_EN
  logic [15:0] timer_q;

  // The watchdog counts only while waiting for the irq and restarts on each entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT_IRQ) timer_q <= '0;
    else                            timer_q <= timer_q + 16'd1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!empty) state_d = WR;
      WR:       if (lastBeat && idx_q == 3'd5) state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (dma_irq) state_d = ACK;
`ifdef DMA_CMD_SEQ_TIMEOUT_EN
        else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) state_d = TMO;
`endif
      end
      ACK:      state_d = DRAIN;
      // A lingering irq must not acknowledge the next descriptor.
      DRAIN:    if (!dma_irq) state_d = IDLE;
      TMO:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: the aux write slot is decoded here and registered below.
  // Each slot is therefore visible one cycle after the FSM selects it.
  always_comb begin
    auxAddr_d = 16'h0000;
    auxData_d = 8'h00;
    if (state_q == WR) begin
      case (idx_q)
        3'd0:    begin auxAddr_d = 16'h0101; auxData_d = curSrc_q[7:0];  end
        3'd1:    begin auxAddr_d = 16'h0102; auxData_d = curSrc_q[15:8]; end
        3'd2:    begin auxAddr_d = 16'h0103; auxData_d = curDst_q[7:0];  end
        3'd3:    begin auxAddr_d = 16'h0104; auxData_d = curDst_q[15:8]; end
        3'd4:    begin auxAddr_d = 16'h0105; auxData_d = curN_q;         end
        3'd5:    begin auxAddr_d = 16'h0100; auxData_d = 8'h00;          end
        default: begin auxAddr_d = 16'h0000; auxData_d = 8'h00;          end
      endcase
    end
    busy    = (state_q != IDLE);
    done    = (state_q == ACK);
    // A timeout also acks so that the dma is left in a clean state.
    dma_ack = (state_q == ACK) || (state_q == TMO);
`ifdef DMA_CMD_SEQ_TIMEOUT_EN
    err     = (state_q == TMO);
`else
    err     = 1'b0;
`endif
  end

  assign dma_auxdaddr = auxAddr_q;
  assign dma_auxdin   = auxData_q;

  // FIFO pointers, current descriptor, slot sequencing and the aux bus register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      curSrc_q  <= '0;
      curDst_q  <= '0;
      curN_q    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      auxAddr_q <= '0;
      auxData_q <= '0;
    end else begin
      count_q   <= count_d;
      auxAddr_q <= auxAddr_d;
      auxData_q <= auxData_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop) begin
        rdPtr_q  <= rdPtr_q + AW'(1);
        curSrc_q <= mem_q[rdPtr_q][39:24];
        curDst_q <= mem_q[rdPtr_q][23:8];
        curN_q   <= mem_q[rdPtr_q][7:0];
        idx_q    <= '0;
        hold_q   <= '0;
      end else if (state_q == WR) begin
        if (lastBeat) begin
          hold_q <= '0;
          idx_q  <= idx_q + 3'd1;
        end else begin
          hold_q <= hold_q + HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_cmd_seq.sv
// Testbench for dma_cmd_seq.
// A producer feeds random descriptors. A reference queue keeps the accepted
// descriptors in order. Each aux write sequence, irq handshake, reset abort
// and FIFO-full stall is checked against that queue and the slot table.
module tb_dma_cmd_seq;

  localparam int H = 2;
  localparam int D = 4;
  localparam int T = 16;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  n;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_src;
  logic [15:0] desc_dst;
  logic [7:0]  desc_n;
  logic [15:0] dma_auxdaddr;
  logic [7:0]  dma_auxdin;
  logic        dma_irq;
  logic        dma_ack;
  logic        busy;
  logic        done;
  logic [$clog2(D):0] pending;
  logic        err;

  int checks = 0;
  int passes = 0;
  int doneCount = 0;
  int ackCount = 0;
  int errCount = 0;
  desc_t offerQ[$];
  desc_t modelQ[$];

  always #5 clk = ~clk;

  dma_cmd_seq #(.FIFO_DEPTH(D), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_n(desc_n),
    .dma_auxdaddr(dma_auxdaddr), .dma_auxdin(dma_auxdin),
    .dma_irq(dma_irq), .dma_ack(dma_ack),
    .busy(busy), .done(done), .pending(pending), .err(err)
  );

  // Compare one observed value with the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Present the next queued offer on the descriptor port, or go idle.
  task automatic loadOffer();
    desc_t d;
    if (offerQ.size() > 0) begin
      d = offerQ.pop_front();
      desc_valid = 1'b1;
      desc_src = d.src;
      desc_dst = d.dst;
      desc_n = d.n;
    end else begin
      desc_valid = 1'b0;
    end
  endtask

  // Queue a descriptor for the producer.
  task automatic applyStimulus(input desc_t d);
    offerQ.push_back(d);
    if (!desc_valid) loadOffer();
  endtask

  function automatic desc_t randDesc();
    desc_t d;
    d.src = 16'($urandom);
    d.dst = 16'($urandom);
    d.n = 8'($urandom);
    return d;
  endfunction

  // Slot k of a descriptor as {address, data}, taken from the register map.
  function automatic logic [23:0] slotOf(input desc_t d, input int k);
    logic [7:0] bytes [6];
    logic [15:0] addr;
    bytes[0] = d.src[7:0];
    bytes[1] = d.src[15:8];
    bytes[2] = d.dst[7:0];
    bytes[3] = d.dst[15:8];
    bytes[4] = d.n;
    bytes[5] = 8'h00;
    addr = (k == 5) ? 16'h0100 : 16'(16'h0101 + k);
    return {addr, bytes[k]};
  endfunction

  // One clock step. Handshakes are decided before the edge and observed after it.
  task automatic tick();
    bit accepted;
    accepted = desc_valid && desc_ready && !rst;
    @(posedge clk);
    @(negedge clk);
    if (accepted) begin
      modelQ.push_back({desc_src, desc_dst, desc_n});
      loadOffer();
    end
    doneCount += int'(done);
    ackCount += int'(dma_ack);
    errCount += int'(err);
  endtask

  // Follow one full write phase of the oldest accepted descriptor.
  // irqSlot >= 0 injects a one-cycle irq in that slot.
  // rstSlot >= 0 resets the block in that slot.
  task automatic expectWrites(input int irqSlot, input int rstSlot);
    desc_t d;
    int waited = 0;
    int ack0 = ackCount;
    int done0 = doneCount;
    bit irqOn = 0;
    while (dma_auxdaddr !== 16'h0101 && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("start_addr_seen", 32'(dma_auxdaddr), 32'h0101);
    d = (modelQ.size() > 0) ? modelQ.pop_front() : '0;
    for (int k = 0; k < 6; k++) begin
      for (int h = 0; h < H; h++) begin
        if (!(k == 0 && h == 0)) begin
          tick();
          if (irqOn) begin
            dma_irq = 1'b0;
            irqOn = 0;
          end
        end
        checkOutput($sformatf("slot%0d_addr", k), 32'(dma_auxdaddr), 32'(slotOf(d, k) >> 8));
        checkOutput($sformatf("slot%0d_data", k), 32'(dma_auxdin), 32'(slotOf(d, k) & 24'hFF));
        if (k == irqSlot && h == 0) begin
          dma_irq = 1'b1;
          irqOn = 1;
        end
        if (k == rstSlot && h == 0) begin
          desc_valid = 1'b0;
          offerQ.delete();
          rst = 1'b1;
          tick();
          rst = 1'b0;
          checkOutput("rst_aux_addr", 32'(dma_auxdaddr), 32'h0);
          checkOutput("rst_aux_data", 32'(dma_auxdin), 32'h0);
          checkOutput("rst_pending", 32'(pending), 32'h0);
          checkOutput("rst_busy", 32'(busy), 32'h0);
          checkOutput("rst_ready", 32'(desc_ready), 32'h1);
          modelQ.delete();
          return;
        end
      end
    end
    tick();
    checkOutput("post_write_addr", 32'(dma_auxdaddr), 32'h0);
    checkOutput("post_write_data", 32'(dma_auxdin), 32'h0);
    checkOutput("wait_busy", 32'(busy), 32'h1);
    checkOutput("no_ack_in_write", 32'(ackCount - ack0), 32'h0);
    checkOutput("no_done_in_write", 32'(doneCount - done0), 32'h0);
  endtask

  // Wait, raise irq for len (>=2) cycles, then drop it.
  // Expect exactly one ack/done pulse, and idle right after the drop.
  task automatic completeIrq(input int delay, input int len);
    int ack0 = ackCount;
    int done0 = doneCount;
    repeat (delay) tick();
    checkOutput("no_ack_before_irq", 32'(ackCount - ack0), 32'h0);
    dma_irq = 1'b1;
    repeat (len) tick();
    checkOutput("busy_while_irq_high", 32'(busy), 32'h1);
    dma_irq = 1'b0;
    tick();
    checkOutput("ack_once", 32'(ackCount - ack0), 32'h1);
    checkOutput("done_once", 32'(doneCount - done0), 32'h1);
    checkOutput("idle_after_irq_drop", 32'(busy), 32'h0);
  endtask

  initial begin
    desc_t d;
    int done0;
    rst = 1'b1;
    desc_valid = 1'b0;
    desc_src = '0;
    desc_dst = '0;
    desc_n = '0;
    dma_irq = 1'b0;
    tick();
    tick();
    doneCount = 0;
    ackCount = 0;
    errCount = 0;
    checkOutput("reset_aux_addr", 32'(dma_auxdaddr), 32'h0);
    checkOutput("reset_aux_data", 32'(dma_auxdin), 32'h0);
    checkOutput("reset_ack", 32'(dma_ack), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_pending", 32'(pending), 32'h0);
    checkOutput("reset_ready", 32'(desc_ready), 32'h1);
    checkOutput("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] directed descriptor with latency checks");
    d.src = 16'h0020;
    d.dst = 16'h0030;
    d.n = 8'h03;
    applyStimulus(d);
    tick();
    checkOutput("push_pending", 32'(pending), 32'h1);
    checkOutput("push_not_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("pop_busy", 32'(busy), 32'h1);
    checkOutput("pop_pending", 32'(pending), 32'h0);
    checkOutput("pop_aux_idle", 32'(dma_auxdaddr), 32'h0);
    tick();
    checkOutput("first_addr_latency", 32'(dma_auxdaddr), 32'h0101);
    expectWrites(-1, -1);
    completeIrq(5, 3);

    $display("[TB] FIFO fill while a descriptor is in progress");
    done0 = doneCount;
    applyStimulus(randDesc());
    expectWrites(-1, -1);
    for (int i = 0; i < 5; i++) applyStimulus(randDesc());
    repeat (4) tick();
    checkOutput("full_pending", 32'(pending), 32'(D));
    checkOutput("full_not_ready", 32'(desc_ready), 32'h0);
    repeat (2) tick();
    checkOutput("stall_pending", 32'(pending), 32'(D));
    checkOutput("stall_not_ready", 32'(desc_ready), 32'h0);
    completeIrq(3, 2);
    for (int i = 0; i < 5; i++) begin
      expectWrites(-1, -1);
      completeIrq(int'($urandom_range(0, 8)), int'($urandom_range(2, 4)));
    end
    checkOutput("fill_done_total", 32'(doneCount - done0), 32'h6);
    checkOutput("fill_drained_pending", 32'(pending), 32'h0);
    checkOutput("fill_drained_ready", 32'(desc_ready), 32'h1);

    $display("[TB] irq during the write phase is ignored");
    applyStimulus(randDesc());
    expectWrites(2, -1);
    completeIrq(2, 2);

    $display("[TB] reset in the middle of a sequence");
    applyStimulus(randDesc());
    applyStimulus(randDesc());
    expectWrites(-1, 3);
    applyStimulus(randDesc());
    expectWrites(-1, -1);
    completeIrq(1, 3);

`ifdef DMA_CMD_SEQ_TIMEOUT_EN
    $display("[TB] irq watchdog");
    begin
      int ack0;
      int err0;
      applyStimulus(randDesc());
      applyStimulus(randDesc());
      expectWrites(-1, -1);
      done0 = doneCount;
      ack0 = ackCount;
      err0 = errCount;
      repeat (T - 2) tick();
      checkOutput("no_err_early", 32'(errCount - err0), 32'h0);
      tick();
      checkOutput("timeout_err", 32'(err), 32'h1);
      checkOutput("timeout_ack", 32'(dma_ack), 32'h1);
      checkOutput("timeout_no_done", 32'(doneCount - done0), 32'h0);
      checkOutput("timeout_ack_count", 32'(ackCount - ack0), 32'h1);
      expectWrites(-1, -1);
      completeIrq(2, 2);
    end
`else
    checkOutput("err_never_pulses", 32'(errCount), 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
